id_ex_register: RTL and testbench
=================================

ID_EX_REGISTER -- requirements
Module: id_ex_register

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port id_valid  in  1  ID stage holds a real instruction.
REQ-004 SHALL have port id_rs1 / id_rs2  in  5 each  ID source register addresses.
REQ-005 SHALL have port id_rd  in  5  ID destination register address.
REQ-006 SHALL have port id_rdata1 / id_rdata2  in  32 each  register-file read data.
REQ-007 SHALL have port id_imm  in  32  decoded immediate.
REQ-008 SHALL have port id_ctrl  in  9  {regWrite[8], memRead[7], memWrite[6], memToReg[5], aluSrc[4], aluOp[3:0]}.
REQ-009 SHALL have port flush  in  1  branch/jump redirect from EX; kill ID instruction.
REQ-010 SHALL have port hold  in  1  global pipeline freeze (memory busy).
REQ-011 SHALL have port wb_rd / wb_regWrite / wb_wdata  in  5/1/32  write-back port, used only under ID_EX_WB_BYPASS_EN.
REQ-012 SHALL have port ex_valid  out  1  EX stage holds a real instruction.
REQ-013 SHALL have port RS_1 / RS_2  out  5 each  registered sources, feed forwarding unit.
REQ-014 SHALL have port ex_rd  out  5  registered destination.
REQ-015 SHALL have port ex_rdata1 / ex_rdata2 / ex_imm  out  32 each  registered operands.
REQ-016 SHALL have port ex_ctrl  out  9  registered control, same bit layout as id_ctrl.
REQ-017 SHALL have port load_use_stall  out  1  combinational; PC and IF/ID must hold.
REQ-018 SHALL have port bubble_cnt  out  8  saturating count of load-use bubbles inserted.

Function
REQ-019 load_use_stall SHALL equal id_valid & ex_valid & ex_ctrl[7] & (ex_rd!=0) & (ex_rd==id_rs1 | ex_rd==id_rs2) & !flush.
REQ-020 Update priority per edge SHALL be: flush > hold > load-use bubble > normal capture.
REQ-021 flush: next ex_valid=0, ex_ctrl=0, RS_1=RS_2=ex_rd=0; data fields don't-care; overrides hold in same cycle.
REQ-022 hold (no flush): every register SHALL keep its value; bubble_cnt unchanged.
REQ-023 load-use (no flush, no hold): insert bubble as in REQ-021 and increment bubble_cnt, saturating at 255.
REQ-024 normal: capture all id_* fields; ex_valid<=id_valid; if id_valid=0 ex_ctrl SHALL be captured as 0.
REQ-025 Latency SHALL be exactly one cycle ID->EX; no combinational path from id_* to ex_* outputs.
REQ-026 A bubble SHALL never assert ex_ctrl[8], [7] or [6], so downstream forwarding never matches it.
REQ-027 After one bubble the hazard SHALL clear (load moved to MEM), so consecutive load-use stalls for one pair never exceed one cycle.

Reset
REQ-028 rst_n low SHALL immediately clear ex_valid, ex_ctrl, RS_1, RS_2, ex_rd, ex_rdata1, ex_rdata2, ex_imm, bubble_cnt to 0, independent of clk.
REQ-029 Reset mid-stall SHALL drop the held instruction; first edge after rst_n rises performs normal capture.

Configuration
REQ-030 With ID_EX_WB_BYPASS_EN defined: on capture, if wb_regWrite & wb_rd!=0 & wb_rd==id_rs1 (resp. id_rs2), ex_rdata1 (resp. ex_rdata2) SHALL take wb_wdata instead of id_rdata.
REQ-031 Without ID_EX_WB_BYPASS_EN: wb_* ports SHALL exist but be ignored; register-file data captured unchanged.

Verification
REQ-032 Reset: drive rst_n=0 mid-cycle with ex_valid=1 -> all outputs 0 before next edge; bubble_cnt=0.
REQ-033 Load-use: EX holds lw x5 (ctrl[7]=1, rd=5), ID add x6,x5,x1 -> load_use_stall=1, next edge ex_valid=0, ex_ctrl=0, bubble_cnt=1; following edge captures the add with RS_1=5.
REQ-034 Flush+hold together with load-use present -> next edge bubble, load_use_stall=0, bubble_cnt unchanged.
REQ-035 hold=1 for 3 cycles with changing id_* -> all ex_* outputs stable; hold=0 -> capture of current id_*.
REQ-036 Bypass enabled: id_rs1=7, id_rdata1=0x11, wb_rd=7, wb_regWrite=1, wb_wdata=0xABCD -> ex_rdata1=0xABCD; wb_rd=0 -> 0x11; disabled -> 0x11.
REQ-037 Saturation: 300 load-use bubbles -> bubble_cnt=255; x0 destination lw (ex_rd=0) -> no stall.

Source files
------------

// File: rtl/id_ex_register_if.sv
// ID/EX pipeline bus: decoded instruction from ID, write-back port, and the registered EX-side view.
// The register itself connects through the slave modport; the ID-side driver uses master.
interface id_ex_register_if;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic [31:0] id_rdata1;
    logic [31:0] id_rdata2;
    logic [31:0] id_imm;
    logic [8:0]  id_ctrl;
    logic        flush;
    logic        hold;
    logic [4:0]  wb_rd;
    logic        wb_regWrite;
    logic [31:0] wb_wdata;

    logic        ex_valid;
    logic [4:0]  RS_1;
    logic [4:0]  RS_2;
    logic [4:0]  ex_rd;
    logic [31:0] ex_rdata1;
    logic [31:0] ex_rdata2;
    logic [31:0] ex_imm;
    logic [8:0]  ex_ctrl;
    logic        load_use_stall;
    logic [7:0]  bubble_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_rdata1, id_rdata2, id_imm, id_ctrl,
        output flush, hold, wb_rd, wb_regWrite, wb_wdata,
        input  ex_valid, RS_1, RS_2, ex_rd, ex_rdata1, ex_rdata2, ex_imm, ex_ctrl,
        input  load_use_stall, bubble_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_rdata1, id_rdata2, id_imm, id_ctrl,
        input  flush, hold, wb_rd, wb_regWrite, wb_wdata,
        output ex_valid, RS_1, RS_2, ex_rd, ex_rdata1, ex_rdata2, ex_imm, ex_ctrl,
        output load_use_stall, bubble_cnt
    );
endinterface

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion and a saturating bubble counter.
// Optional write-back bypass into the captured operands is enabled by defining ID_EX_WB_BYPASS_EN.
module id_ex_register (
    input logic             clk,
    input logic             rst_n,
    id_ex_register_if.slave bus
);

    logic        ex_valid_q,   ex_valid_d;
    logic [4:0]  rs1_q,        rs1_d;
    logic [4:0]  rs2_q,        rs2_d;
    logic [4:0]  ex_rd_q,      ex_rd_d;
    logic [31:0] ex_rdata1_q,  ex_rdata1_d;
    logic [31:0] ex_rdata2_q,  ex_rdata2_d;
    logic [31:0] ex_imm_q,     ex_imm_d;
    logic [8:0]  ex_ctrl_q,    ex_ctrl_d;
    logic [7:0]  bubble_cnt_q, bubble_cnt_d;

    logic        load_use;
    logic [31:0] op1_sel;
    logic [31:0] op2_sel;

    // A load in EX whose destination is read by the instruction in ID must wait one cycle.
    assign load_use = bus.id_valid && ex_valid_q && ex_ctrl_q[7] && (ex_rd_q != 5'd0) &&
                      ((ex_rd_q == bus.id_rs1) || (ex_rd_q == bus.id_rs2)) && !bus.flush;

`ifdef ID_EX_WB_BYPASS_EN
    assign op1_sel = (bus.wb_regWrite && (bus.wb_rd != 5'd0) && (bus.wb_rd == bus.id_rs1))
                     ? bus.wb_wdata : bus.id_rdata1;
    assign op2_sel = (bus.wb_regWrite && (bus.wb_rd != 5'd0) && (bus.wb_rd == bus.id_rs2))
                     ? bus.wb_wdata : bus.id_rdata2;
`else
    logic wb_unused;
    assign wb_unused = ^{bus.wb_rd, bus.wb_regWrite, bus.wb_wdata};
    assign op1_sel   = bus.id_rdata1;
    assign op2_sel   = bus.id_rdata2;
`endif

    always_comb begin
        // NOTE: every next-state value defaults to its register so no path through this block infers a latch.
        ex_valid_d   = ex_valid_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        ex_rd_d      = ex_rd_q;
        ex_rdata1_d  = ex_rdata1_q;
        ex_rdata2_d  = ex_rdata2_q;
        ex_imm_d     = ex_imm_q;
        ex_ctrl_d    = ex_ctrl_q;
        bubble_cnt_d = bubble_cnt_q;

        if (bus.flush || (!bus.hold && load_use)) begin
            // Bubble: zeroed control and addresses so forwarding never matches it; data left as-is.
            ex_valid_d = 1'b0;
            ex_ctrl_d  = 9'd0;
            rs1_d      = 5'd0;
            rs2_d      = 5'd0;
            ex_rd_d    = 5'd0;
            if (!bus.flush && bubble_cnt_q != 8'hFF) begin
                bubble_cnt_d = bubble_cnt_q + 8'd1;
            end
        end else if (!bus.hold) begin
            ex_valid_d  = bus.id_valid;
            rs1_d       = bus.id_rs1;
            rs2_d       = bus.id_rs2;
            ex_rd_d     = bus.id_rd;
            ex_rdata1_d = op1_sel;
            ex_rdata2_d = op2_sel;
            ex_imm_d    = bus.id_imm;
            ex_ctrl_d   = bus.id_valid ? bus.id_ctrl : 9'd0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q   <= 1'b0;
            rs1_q        <= 5'd0;
            rs2_q        <= 5'd0;
            ex_rd_q      <= 5'd0;
            ex_rdata1_q  <= 32'd0;
            ex_rdata2_q  <= 32'd0;
            ex_imm_q     <= 32'd0;
            ex_ctrl_q    <= 9'd0;
            bubble_cnt_q <= 8'd0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            ex_rd_q      <= ex_rd_d;
            ex_rdata1_q  <= ex_rdata1_d;
            ex_rdata2_q  <= ex_rdata2_d;
            ex_imm_q     <= ex_imm_d;
            ex_ctrl_q    <= ex_ctrl_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.ex_valid       = ex_valid_q;
    assign bus.RS_1           = rs1_q;
    assign bus.RS_2           = rs2_q;
    assign bus.ex_rd          = ex_rd_q;
    assign bus.ex_rdata1      = ex_rdata1_q;
    assign bus.ex_rdata2      = ex_rdata2_q;
    assign bus.ex_imm         = ex_imm_q;
    assign bus.ex_ctrl        = ex_ctrl_q;
    assign bus.load_use_stall = load_use;
    assign bus.bubble_cnt     = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_register.sv
// Directed self-checking bench for id_ex_register: reset, capture, load-use bubbles, flush/hold priority,
// write-back bypass (expectation follows ID_EX_WB_BYPASS_EN) and counter saturation.
module tb_id_ex_register;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    id_ex_register_if bus ();

    id_ex_register dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                            input logic [31:0] imm, input logic [8:0] ctrl);
        bus.id_valid  = v;
        bus.id_rs1    = rs1;
        bus.id_rs2    = rs2;
        bus.id_rd     = rd;
        bus.id_rdata1 = d1;
        bus.id_rdata2 = d2;
        bus.id_imm    = imm;
        bus.id_ctrl   = ctrl;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".ex_valid"},   {31'd0, bus.ex_valid}, 32'd0);
        check({tag, ".ex_ctrl"},    {23'd0, bus.ex_ctrl},  32'd0);
        check({tag, ".RS_1"},       {27'd0, bus.RS_1},     32'd0);
        check({tag, ".RS_2"},       {27'd0, bus.RS_2},     32'd0);
        check({tag, ".ex_rd"},      {27'd0, bus.ex_rd},    32'd0);
        check({tag, ".ex_rdata1"},  bus.ex_rdata1,         32'd0);
        check({tag, ".ex_rdata2"},  bus.ex_rdata2,         32'd0);
        check({tag, ".ex_imm"},     bus.ex_imm,            32'd0);
        check({tag, ".bubble_cnt"}, {24'd0, bus.bubble_cnt}, 32'd0);
    endtask

    localparam logic [8:0] CTRL_LW  = 9'h1A0;  // regWrite | memRead | memToReg
    localparam logic [8:0] CTRL_ADD = 9'h100;

`ifdef ID_EX_WB_BYPASS_EN
    localparam logic [31:0] BYP_EXP = 32'h0000_ABCD;
`else
    localparam logic [31:0] BYP_EXP = 32'h0000_0011;
`endif

    initial begin
        rst_n = 1'b0;
        bus.flush = 1'b0;
        bus.hold = 1'b0;
        bus.wb_rd = 5'd0;
        bus.wb_regWrite = 1'b0;
        bus.wb_wdata = 32'd0;
        drive_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 9'd0);
        #1;
        check_all_zero("reset");
        #11 rst_n = 1'b1;

        // Normal capture
        drive_id(1'b1, 5'd1, 5'd2, 5'd3, 32'h1111_1111, 32'h2222_2222, 32'h0000_0333, 9'h10A);
        step();
        check("cap.ex_valid",  {31'd0, bus.ex_valid}, 32'd1);
        check("cap.RS_1",      {27'd0, bus.RS_1},     32'd1);
        check("cap.RS_2",      {27'd0, bus.RS_2},     32'd2);
        check("cap.ex_rd",     {27'd0, bus.ex_rd},    32'd3);
        check("cap.ex_rdata1", bus.ex_rdata1,         32'h1111_1111);
        check("cap.ex_rdata2", bus.ex_rdata2,         32'h2222_2222);
        check("cap.ex_imm",    bus.ex_imm,            32'h0000_0333);
        check("cap.ex_ctrl",   {23'd0, bus.ex_ctrl},  32'h10A);

        // Invalid instruction captures zero control
        drive_id(1'b0, 5'd4, 5'd5, 5'd6, 32'h1, 32'h2, 32'h3, 9'h1FF);
        step();
        check("inv.ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        check("inv.ex_ctrl",  {23'd0, bus.ex_ctrl},  32'd0);

        // Load-use: lw x5 then add x6,x5,x1
        drive_id(1'b1, 5'd2, 5'd0, 5'd5, 32'h100, 32'h0, 32'h4, CTRL_LW);
        #1;
        check("lw.no_stall", {31'd0, bus.load_use_stall}, 32'd0);
        step();
        drive_id(1'b1, 5'd5, 5'd1, 5'd6, 32'h55, 32'h66, 32'h0, CTRL_ADD);
        #1;
        check("lu.stall", {31'd0, bus.load_use_stall}, 32'd1);
        step();
        check("lu.bub_valid", {31'd0, bus.ex_valid},   32'd0);
        check("lu.bub_ctrl",  {23'd0, bus.ex_ctrl},    32'd0);
        check("lu.bub_rd",    {27'd0, bus.ex_rd},      32'd0);
        check("lu.bub_cnt",   {24'd0, bus.bubble_cnt}, 32'd1);
        check("lu.cleared",   {31'd0, bus.load_use_stall}, 32'd0);
        step();
        check("lu.add_valid", {31'd0, bus.ex_valid}, 32'd1);
        check("lu.add_RS_1",  {27'd0, bus.RS_1},     32'd5);
        check("lu.add_rd",    {27'd0, bus.ex_rd},    32'd6);
        check("lu.add_ctrl",  {23'd0, bus.ex_ctrl},  32'h100);

        // Flush and hold together with a load-use hazard present
        drive_id(1'b1, 5'd2, 5'd0, 5'd5, 32'h100, 32'h0, 32'h4, CTRL_LW);
        step();
        drive_id(1'b1, 5'd5, 5'd1, 5'd6, 32'h55, 32'h66, 32'h0, CTRL_ADD);
        bus.flush = 1'b1;
        bus.hold  = 1'b1;
        #1;
        check("fh.stall", {31'd0, bus.load_use_stall}, 32'd0);
        step();
        bus.flush = 1'b0;
        bus.hold  = 1'b0;
        check("fh.valid", {31'd0, bus.ex_valid},   32'd0);
        check("fh.ctrl",  {23'd0, bus.ex_ctrl},    32'd0);
        check("fh.RS_1",  {27'd0, bus.RS_1},       32'd0);
        check("fh.cnt",   {24'd0, bus.bubble_cnt}, 32'd1);

        // Hold for three cycles while ID changes
        drive_id(1'b1, 5'd3, 5'd4, 5'd9, 32'hA1, 32'hA2, 32'hA3, 9'h113);
        step();
        check("hold.pre", bus.ex_rdata1, 32'hA1);
        bus.hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_id(1'b1, 5'd3, 5'd4, 5'(10 + i), 32'(32'hB0 + i), 32'hA2, 32'(32'hC0 + i), 9'h011);
            step();
            check("hold.rdata1", bus.ex_rdata1,         32'hA1);
            check("hold.rd",     {27'd0, bus.ex_rd},    32'd9);
            check("hold.imm",    bus.ex_imm,            32'hA3);
            check("hold.ctrl",   {23'd0, bus.ex_ctrl},  32'h113);
            check("hold.valid",  {31'd0, bus.ex_valid}, 32'd1);
        end
        bus.hold = 1'b0;
        step();
        check("rel.rdata1", bus.ex_rdata1,        32'hB2);
        check("rel.rd",     {27'd0, bus.ex_rd},   32'd12);
        check("rel.imm",    bus.ex_imm,           32'hC2);
        check("rel.ctrl",   {23'd0, bus.ex_ctrl}, 32'h011);

        // Write-back bypass
        drive_id(1'b1, 5'd7, 5'd8, 5'd9, 32'h11, 32'h22, 32'h0, 9'h104);
        bus.wb_rd       = 5'd7;
        bus.wb_regWrite = 1'b1;
        bus.wb_wdata    = 32'hABCD;
        step();
        check("byp.rdata1", bus.ex_rdata1, BYP_EXP);
        check("byp.rdata2", bus.ex_rdata2, 32'h22);
        bus.wb_rd = 5'd0;
        step();
        check("byp.x0", bus.ex_rdata1, 32'h11);
        bus.wb_regWrite = 1'b0;

        // Load to x0 never stalls
        drive_id(1'b1, 5'd2, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, CTRL_LW);
        step();
        drive_id(1'b1, 5'd0, 5'd0, 5'd6, 32'h0, 32'h0, 32'h0, CTRL_ADD);
        #1;
        check("x0.stall", {31'd0, bus.load_use_stall}, 32'd0);
        step();
        check("x0.valid", {31'd0, bus.ex_valid},   32'd1);
        check("x0.cnt",   {24'd0, bus.bubble_cnt}, 32'd1);

        // Saturation: "lw x5,0(x5)" in ID alternates capture / bubble; 300 bubbles in 600 cycles
        drive_id(1'b1, 5'd5, 5'd0, 5'd5, 32'h0, 32'h0, 32'h0, CTRL_LW);
        for (int i = 0; i < 600; i++) step();
        check("sat.cnt",      {24'd0, bus.bubble_cnt}, 32'd255);
        check("sat.no_stall", {31'd0, bus.load_use_stall}, 32'd0);
        step();
        check("sat.stall",    {31'd0, bus.load_use_stall}, 32'd1);

        // Asynchronous reset mid-stall, then normal capture on first edge
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        check("midrst.stall", {31'd0, bus.load_use_stall}, 32'd0);
        #1 rst_n = 1'b1;
        step();
        check("post.valid", {31'd0, bus.ex_valid},   32'd1);
        check("post.rd",    {27'd0, bus.ex_rd},      32'd5);
        check("post.ctrl",  {23'd0, bus.ex_ctrl},    32'h1A0);
        check("post.cnt",   {24'd0, bus.bubble_cnt}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
